// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM states, default settle
// time, the four lab reference tables and a counter-width helper.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

  localparam int DEF_SETTLE_CYCLES = 1;

  localparam logic [15:0] TT1 = 16'h7F01;
  localparam logic [7:0]  TT2 = 8'hBB;
  localparam logic [15:0] TT3 = 16'hFAF2;
  localparam logic [7:0]  TT4 = 8'hCD;

  // Settle counter only ever holds SETTLE_CYCLES-1, so clog2 bits suffice.
  function automatic int cnt_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/sweep_settle_counter.sv
// Loadable down-counter with zero flag; times how long each stimulus row is
// held before Y is sampled.
module sweep_settle_counter #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every A..D combination onto a combinational table module and captures
// its Y into one packed word. Optional TT_COMPARE_EN adds expected_in / match.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_INPUTS      = 4,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   y_in,
  output logic [N_INPUTS-1:0]    abcd_out,
  output logic                   busy,
  output logic                   done,
  output logic [2**N_INPUTS-1:0] table_out
`ifdef TT_COMPARE_EN
  ,
  input  logic [2**N_INPUTS-1:0] expected_in,
  output logic                   match
`endif
);

  localparam int ROWS  = 2**N_INPUTS;
  localparam int CNT_W = cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]    RELOAD   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] LAST_ROW = N_INPUTS'(ROWS - 1);

  sweep_state_t        state, state_nxt;
  logic [N_INPUTS-1:0] idx;
  logic [ROWS-1:0]     table_nxt;
  logic                accept;
  logic                last_row;
  logic                cnt_load;
  logic                cnt_dec;
  logic                cnt_zero;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_row = (idx == LAST_ROW);

  sweep_settle_counter #(
    .CNT_W(CNT_W)
  ) u_settle (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .load_val(RELOAD),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = SETTLE;
          cnt_load  = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          state_nxt = SAMPLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      SAMPLE: begin
        if (last_row) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SETTLE;
          cnt_load  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Current table with the row under sample merged in.
  always_comb begin
    table_nxt      = table_out;
    table_nxt[idx] = y_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      table_out <= '0;
    end else if (accept) begin
      idx       <= '0;
      table_out <= '0;
    end else if (state == SAMPLE) begin
      table_out <= table_nxt;
      if (!last_row) begin
        idx <= idx + N_INPUTS'(1);
      end
    end
  end

`ifdef TT_COMPARE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match <= 1'b0;
    end else if (accept) begin
      match <= 1'b0;
    end else if ((state == SAMPLE) && last_row) begin
      match <= (table_nxt == expected_in);
    end
  end
`endif

  assign abcd_out = idx;
  assign busy     = (state == SETTLE) || (state == SAMPLE);
  assign done     = (state == DONE);

endmodule
